tc11_to_binary_pipe: RTL

Streaming decoder from the 10-bit modulo-11 thermometer code back to a 4-bit binary residue. It is the inverse of the binary-to-TC11 encoder and sits at the output of the thermometer-domain modulo-11 adder. Each input word is checked for legal thermometer form. The block is a 2-stage valid/ready pipeline with full throughput, an error flag per word, and a saturating error counter.

---
 rtl/tc11_to_binary_pipe_if.sv | 27 ++
 rtl/tc11_to_binary_pipe.sv | 103 ++++++++++
 2 files changed

// File: rtl/tc11_to_binary_pipe_if.sv
// Handshake/data bundle for tc11_to_binary_pipe.
//   in_valid/in_ready/in     : thermometer-code input stream (in[1] = LSB)
//   out_valid/out_ready/out  : decoded binary residue stream
//   err                      : current output word was illegal thermometer code
//   err_clr / err_cnt        : synchronous clear / saturating error counter
// master = upstream+downstream environment, slave = the decoder.
interface tc11_to_binary_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [10:1] in;
  logic        out_valid;
  logic        out_ready;
  logic [4:1]  out;
  logic        err;
  logic        err_clr;
  logic [8:1]  err_cnt;

  modport master (
    output in_valid, in, out_ready, err_clr,
    input  in_ready, out_valid, out, err, err_cnt
  );

  modport slave (
    input  in_valid, in, out_ready, err_clr,
    output in_ready, out_valid, out, err, err_cnt
  );
endinterface

// File: rtl/tc11_to_binary_pipe.sv
// tc11_to_binary_pipe: 2-stage valid/ready decoder, 10-bit modulo-11
// thermometer code -> 4-bit binary residue, with per-word error flag and a
// saturating error counter.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    tc11_to_binary_pipe_if.slave (streams, err, err_clr, err_cnt)
// Build option: TC11_BUBBLE_CORR_EN -- illegal words decode to popcount(in)
// instead of 4'hF (err still raised and counted).
module tc11_to_binary_pipe (
  input  logic                    clk,
  input  logic                    rst_n,
  tc11_to_binary_pipe_if.slave    bus
);

  logic        w_s2_ld, w_s1_ld, w_legal;
  logic [10:2] w_bubble;
  logic [4:1]  w_hi, w_dec;

  logic        r_s1_vld, r_s1_legal;
  logic [10:1] r_s1_code;
  logic        r_out_vld, r_err;
  logic [4:1]  r_out;
  logic [8:1]  r_err_cnt;

  // Classic skid-free 2-deep pipe: each stage loads when it is empty or the
  // stage after it is draining. in_ready never looks at in_valid.
  assign w_s2_ld = ~r_out_vld | bus.out_ready;
  assign w_s1_ld = ~r_s1_vld | w_s2_ld;

  // A bubble is a set bit sitting above a clear one.
  genvar gi;
  generate
    for (gi = 2; gi <= 10; gi++) begin : g_bub
      assign w_bubble[gi] = bus.in[gi] & ~bus.in[gi-1];
    end
  endgenerate
  assign w_legal = ~|w_bubble;

  // Highest set bit index; 0 for all-zeros. Equals k for a legal 2^k-1.
  always_comb begin
    w_hi = 4'd0;
    for (int i = 1; i <= 10; i++)
      if (r_s1_code[i]) w_hi = 4'(i);
  end

`ifdef TC11_BUBBLE_CORR_EN
  logic [4:1] w_pop;
  always_comb begin
    w_pop = 4'd0;
    for (int i = 1; i <= 10; i++)
      w_pop = w_pop + {3'd0, r_s1_code[i]};
  end
  assign w_dec = r_s1_legal ? w_hi : w_pop;
`else
  assign w_dec = r_s1_legal ? w_hi : 4'hF;
`endif

  // S1: capture code and legality.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld   <= 1'b0;
      r_s1_legal <= 1'b0;
      r_s1_code  <= '0;
    end else if (w_s1_ld) begin
      r_s1_vld   <= bus.in_valid;
      r_s1_legal <= w_legal;
      r_s1_code  <= bus.in;
    end
  end

  // S2: decoded value and error flag; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_out     <= '0;
      r_err     <= 1'b0;
    end else if (w_s2_ld) begin
      r_out_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out <= w_dec;
        r_err <= ~r_s1_legal;
      end
    end
  end

  // Counts erroneous words on output transfer; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (bus.err_clr)
      r_err_cnt <= '0;
    else if (r_out_vld & bus.out_ready & r_err & (r_err_cnt != 8'hFF))
      r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign bus.in_ready  = w_s1_ld;
  assign bus.out_valid = r_out_vld;
  assign bus.out       = r_out;
  assign bus.err       = r_err;
  assign bus.err_cnt   = r_err_cnt;

endmodule
